// File: rtl/pong_game_sequencer.sv
// Game-flow controller for Pong: serves the ball, paces physics once per frame,
// tallies misses into scores and declares a winner.
module pong_game_sequencer #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int SERVE_VX     = 2,
    parameter int SERVE_VY     = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_tick,
    input  logic        i_start,
    input  logic        i_phys_done,
    input  logic [1:0]  i_phys_miss,
    output logic        o_phys_step,
    output logic        o_phys_load,
    output logic [31:0] o_ball_pos_init,
    output logic [15:0] o_ball_vel_init,
    output logic [3:0]  o_score_left,
    output logic [3:0]  o_score_right,
    output logic [1:0]  o_winner,
    output logic [2:0]  o_game_state,
    output logic        o_frame_overrun
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_WAIT  = 3'd3,
        S_SCORE = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam logic [15:0] POS_X      = 16'(SCREEN_W / 2);
    localparam logic [15:0] POS_Y      = 16'(SCREEN_H / 2);
    localparam logic [7:0]  VX_POS     = 8'(SERVE_VX);
    localparam logic [7:0]  VX_NEG     = 8'(-SERVE_VX);
    localparam logic [7:0]  VY         = 8'(SERVE_VY);
    localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
    localparam logic [15:0] SERVE_LOAD = (SERVE_FRAMES < 1) ? 16'd1 : 16'(SERVE_FRAMES);

    state_t      r_state, w_state;
    logic [15:0] r_serve_cnt, w_serve_cnt;
    logic        r_serve_left, w_serve_left;
    logic [1:0]  r_miss, w_miss;
    logic        r_phys_step, w_phys_step;
    logic        r_phys_load, w_phys_load;
    logic [31:0] r_pos, w_pos;
    logic [15:0] r_vel, w_vel;
    logic [3:0]  r_score_l, w_score_l;
    logic [3:0]  r_score_r, w_score_r;
    logic [1:0]  r_winner, w_winner;
    logic        r_overrun, w_overrun;
    logic        w_enter_serve;
    logic        w_left_pt, w_right_pt;

    always_comb begin
        w_state       = r_state;
        w_serve_cnt   = r_serve_cnt;
        w_serve_left  = r_serve_left;
        w_miss        = r_miss;
        w_phys_step   = 1'b0;
        w_phys_load   = 1'b0;
        w_pos         = r_pos;
        w_vel         = r_vel;
        w_score_l     = r_score_l;
        w_score_r     = r_score_r;
        w_winner      = r_winner;
        w_overrun     = r_overrun;
        w_enter_serve = 1'b0;
        w_left_pt     = 1'b0;
        w_right_pt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_score_l     = 4'd0;
                    w_score_r     = 4'd0;
                    w_winner      = 2'b00;
                    w_enter_serve = 1'b1;
                end
            end
            S_SERVE: begin
                if (i_frame_tick) begin
                    if (r_serve_cnt <= 16'd1) begin
                        w_state = S_PLAY;
                    end else begin
                        w_serve_cnt = r_serve_cnt - 16'd1;
                    end
                end
            end
            S_PLAY: begin
                if (i_frame_tick) begin
                    w_phys_step = 1'b1;
                    w_state     = S_WAIT;
                end
            end
            S_WAIT: begin
                // A tick here means physics is too slow; it is flagged and dropped.
                if (i_frame_tick) begin
                    w_overrun = 1'b1;
                end
                if (i_phys_done) begin
                    w_miss  = i_phys_miss;
                    w_state = (i_phys_miss == 2'b00) ? S_PLAY : S_SCORE;
                end
            end
            S_SCORE: begin
                w_left_pt  = (r_miss == 2'b01);
                w_right_pt = (r_miss == 2'b10);
                case (r_miss)
                    2'b01:   w_serve_left = 1'b1;
                    2'b10:   w_serve_left = 1'b0;
                    2'b11:   w_serve_left = ~r_serve_left;
                    default: w_serve_left = r_serve_left;
                endcase
                if (w_left_pt && r_score_l != 4'hF) begin
                    w_score_l = r_score_l + 4'd1;
                end
                if (w_right_pt && r_score_r != 4'hF) begin
                    w_score_r = r_score_r + 4'd1;
                end
                if (w_left_pt && w_score_l == WIN) begin
                    w_winner = 2'b01;
                    w_state  = S_OVER;
                end else if (w_right_pt && w_score_r == WIN) begin
                    w_winner = 2'b10;
                    w_state  = S_OVER;
                end else begin
                    w_enter_serve = 1'b1;
                end
            end
            S_OVER: begin
                if (i_start) begin
                    w_score_l     = 4'd0;
                    w_score_r     = 4'd0;
                    w_winner      = 2'b00;
                    w_overrun     = 1'b0;
                    w_enter_serve = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Every path into SERVE loads the ball at centre using the latest direction.
        if (w_enter_serve) begin
            w_state     = S_SERVE;
            w_phys_load = 1'b1;
            w_pos       = {POS_X, POS_Y};
            w_vel       = {(w_serve_left ? VX_NEG : VX_POS), VY};
            w_serve_cnt = SERVE_LOAD;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_serve_cnt  <= 16'd0;
            r_serve_left <= 1'b0;
            r_miss       <= 2'b00;
            r_phys_step  <= 1'b0;
            r_phys_load  <= 1'b0;
            r_pos        <= 32'd0;
            r_vel        <= 16'd0;
            r_score_l    <= 4'd0;
            r_score_r    <= 4'd0;
            r_winner     <= 2'b00;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_serve_cnt  <= w_serve_cnt;
            r_serve_left <= w_serve_left;
            r_miss       <= w_miss;
            r_phys_step  <= w_phys_step;
            r_phys_load  <= w_phys_load;
            r_pos        <= w_pos;
            r_vel        <= w_vel;
            r_score_l    <= w_score_l;
            r_score_r    <= w_score_r;
            r_winner     <= w_winner;
            r_overrun    <= w_overrun;
        end
    end

    assign o_phys_step     = r_phys_step;
    assign o_phys_load     = r_phys_load;
    assign o_ball_pos_init = r_pos;
    assign o_ball_vel_init = r_vel;
    assign o_score_left    = r_score_l;
    assign o_score_right   = r_score_r;
    assign o_winner        = r_winner;
    assign o_game_state    = r_state;
    assign o_frame_overrun = r_overrun;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Randomized bench for pong_game_sequencer: a point-level game model predicts
// scores, serve direction, winner and overrun while the bench plays full games.
module tb_pong_game_sequencer;

    localparam int ST_IDLE  = 0;
    localparam int ST_SERVE = 1;
    localparam int ST_PLAY  = 2;
    localparam int ST_WAIT  = 3;
    localparam int ST_SCORE = 4;
    localparam int ST_OVER  = 5;
    localparam int SERVE_FRAMES = 60;
    localparam int WIN_POINTS   = 7;
    localparam logic [31:0] CENTRE_POS = 32'h0140_00F0;
    localparam logic [15:0] VEL_RIGHT  = 16'h0201;
    localparam logic [15:0] VEL_LEFT   = 16'hFE01;

    logic        clk = 1'b0;
    logic        rstN;
    logic        frameTick;
    logic        start;
    logic        physDone;
    logic [1:0]  physMiss;
    logic        physStep;
    logic        physLoad;
    logic [31:0] ballPosInit;
    logic [15:0] ballVelInit;
    logic [3:0]  scoreLeft;
    logic [3:0]  scoreRight;
    logic [1:0]  winner;
    logic [2:0]  gameState;
    logic        frameOverrun;

    int testsRun  = 0;
    int failCount = 0;

    int mScoreL;
    int mScoreR;
    int mServeLeft;
    int mWinner;
    int mOverrun;

    pong_game_sequencer dut (
        .i_clk           (clk),
        .i_rst_n         (rstN),
        .i_frame_tick    (frameTick),
        .i_start         (start),
        .i_phys_done     (physDone),
        .i_phys_miss     (physMiss),
        .o_phys_step     (physStep),
        .o_phys_load     (physLoad),
        .o_ball_pos_init (ballPosInit),
        .o_ball_vel_init (ballVelInit),
        .o_score_left    (scoreLeft),
        .o_score_right   (scoreRight),
        .o_winner        (winner),
        .o_game_state    (gameState),
        .o_frame_overrun (frameOverrun)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at a falling edge; outputs are sampled at the next falling edge.
    task automatic applyStimulus(input logic tick, input logic st, input logic done, input logic [1:0] miss);
        frameTick = tick;
        start     = st;
        physDone  = done;
        physMiss  = miss;
        @(negedge clk);
        frameTick = 1'b0;
        start     = 1'b0;
        physDone  = 1'b0;
        physMiss  = 2'b00;
    endtask

    function automatic logic [15:0] expVel();
        return (mServeLeft != 0) ? VEL_LEFT : VEL_RIGHT;
    endfunction

    task automatic modelReset();
        mScoreL    = 0;
        mScoreR    = 0;
        mServeLeft = 0;
        mWinner    = 0;
        mOverrun   = 0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "State"},   gameState,    ST_IDLE);
        checkOutput({tag, "Step"},    physStep,     0);
        checkOutput({tag, "Load"},    physLoad,     0);
        checkOutput({tag, "Pos"},     ballPosInit,  0);
        checkOutput({tag, "Vel"},     ballVelInit,  0);
        checkOutput({tag, "ScoreL"},  scoreLeft,    0);
        checkOutput({tag, "ScoreR"},  scoreRight,   0);
        checkOutput({tag, "Winner"},  winner,       0);
        checkOutput({tag, "Overrun"}, frameOverrun, 0);
    endtask

    task automatic checkServeEntry(input string tag);
        checkOutput({tag, "State"}, gameState,   ST_SERVE);
        checkOutput({tag, "Load"},  physLoad,    1);
        checkOutput({tag, "Step"},  physStep,    0);
        checkOutput({tag, "Pos"},   ballPosInit, CENTRE_POS);
        checkOutput({tag, "Vel"},   ballVelInit, expVel());
    endtask

    // Count down the serve hold, with random idle cycles and stray phys_done pulses.
    task automatic runServe();
        for (int i = 1; i <= SERVE_FRAMES; i++) begin
            repeat ($urandom_range(0, 2)) begin
                applyStimulus(1'b0, 1'b0, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
                checkOutput("serveIdleState", gameState, ST_SERVE);
                checkOutput("serveIdleLoad", physLoad, 0);
            end
            applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
            checkOutput("serveTickState", gameState, (i == SERVE_FRAMES) ? ST_PLAY : ST_SERVE);
            checkOutput("serveTickStep", physStep, 0);
        end
        checkOutput("servePos", ballPosInit, CENTRE_POS);
        checkOutput("serveVel", ballVelInit, expVel());
    endtask

    // A few clean rallies, then one physics step that reports finalMiss.
    task automatic runRally(input logic [1:0] finalMiss);
        int rallies;
        logic sameTick;
        logic [1:0] m;
        rallies = $urandom_range(0, 3);
        for (int r = 0; r <= rallies; r++) begin
            m = (r == rallies) ? finalMiss : 2'b00;
            repeat ($urandom_range(0, 1)) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
                checkOutput("playHoldState", gameState, ST_PLAY);
                checkOutput("playHoldStep", physStep, 0);
            end
            applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
            checkOutput("stepState", gameState, ST_WAIT);
            checkOutput("stepPulse", physStep, 1);
            applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
            checkOutput("stepPulseEnd", physStep, 0);
            checkOutput("waitState", gameState, ST_WAIT);
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
                mOverrun = 1;
                checkOutput("waitTickOverrun", frameOverrun, mOverrun);
                checkOutput("waitTickNoStep", physStep, 0);
                checkOutput("waitTickState", gameState, ST_WAIT);
            end
            sameTick = ($urandom_range(0, 5) == 0);
            if (sameTick) mOverrun = 1;
            applyStimulus(sameTick, 1'b0, 1'b1, m);
            checkOutput("doneOverrun", frameOverrun, mOverrun);
            checkOutput("doneState", gameState, (m == 2'b00) ? ST_PLAY : ST_SCORE);
            checkOutput("doneScoreL", scoreLeft, mScoreL);
            checkOutput("doneScoreR", scoreRight, mScoreR);
        end
    endtask

    task automatic scorePhase(input logic [1:0] miss);
        if (miss == 2'b01) begin
            if (mScoreL < 15) mScoreL++;
            mServeLeft = 1;
            if (mScoreL == WIN_POINTS) mWinner = 1;
        end else if (miss == 2'b10) begin
            if (mScoreR < 15) mScoreR++;
            mServeLeft = 0;
            if (mScoreR == WIN_POINTS) mWinner = 2;
        end else begin
            mServeLeft = (mServeLeft != 0) ? 0 : 1;
        end
        applyStimulus(($urandom_range(0, 1) == 1), 1'b0, 1'b0, 2'b00);
        checkOutput("scoreLeft", scoreLeft, mScoreL);
        checkOutput("scoreRight", scoreRight, mScoreR);
        checkOutput("winner", winner, mWinner);
        checkOutput("scoreOverrun", frameOverrun, mOverrun);
        if (mWinner != 0) begin
            checkOutput("overState", gameState, ST_OVER);
            checkOutput("overLoad", physLoad, 0);
        end else begin
            checkServeEntry("reserve");
        end
    endtask

    task automatic playGame(input int gameIdx);
        int point;
        int r;
        logic [1:0] m;
        point = 0;
        while (mWinner == 0 && point < 60) begin
            runServe();
            if (gameIdx == 0 && point < 3) begin
                m = (point == 0) ? 2'b01 : ((point == 1) ? 2'b10 : 2'b11);
            end else begin
                r = $urandom_range(0, 4);
                m = (r < 2) ? 2'b01 : ((r < 4) ? 2'b10 : 2'b11);
            end
            runRally(m);
            scorePhase(m);
            point++;
        end
    endtask

    task automatic overAndRestart();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(($urandom_range(0, 1) == 1), 1'b0, ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)));
            checkOutput("overHoldState", gameState, ST_OVER);
            checkOutput("overHoldStep", physStep, 0);
            checkOutput("overHoldLoad", physLoad, 0);
            checkOutput("overHoldScoreL", scoreLeft, mScoreL);
            checkOutput("overHoldScoreR", scoreRight, mScoreR);
            checkOutput("overHoldWinner", winner, mWinner);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
        mScoreL  = 0;
        mScoreR  = 0;
        mWinner  = 0;
        mOverrun = 0;
        checkServeEntry("restart");
        checkOutput("restartScoreL", scoreLeft, 0);
        checkOutput("restartScoreR", scoreRight, 0);
        checkOutput("restartWinner", winner, 0);
        checkOutput("restartOverrun", frameOverrun, 0);
    endtask

    initial begin
        rstN      = 1'b0;
        frameTick = 1'b0;
        start     = 1'b0;
        physDone  = 1'b0;
        physMiss  = 2'b00;
        modelReset();
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rstN = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b01);
        checkAllZero("idleIgnore");

        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
        checkServeEntry("firstServe");
        playGame(0);
        overAndRestart();
        playGame(1);
        overAndRestart();

        // Asynchronous reset while waiting on physics, after an overrun.
        runServe();
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
        checkOutput("preResetState", gameState, ST_WAIT);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
        checkOutput("preResetOverrun", frameOverrun, 1);
        #2 rstN = 1'b0;
        #1 checkAllZero("asyncReset");
        @(negedge clk);
        rstN = 1'b1;
        modelReset();
        repeat (3) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
            checkAllZero("postReset");
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
        checkServeEntry("postResetServe");

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/pong_game_sequencer.md
Name: pong_game_sequencer

Overview:
Top-level game-flow controller for the Pong datapath. It paces the paddle/ball physics block once per video frame and serves the ball. It tallies points from physics miss reports and declares a winner. It sits between the display timing generator (frame_tick), the user start button, and the physics block, which it loads and steps.

Parameters:
SCREEN_W, 640, playfield width in pixels; serve X = SCREEN_W/2
SCREEN_H, 480, playfield height in pixels; serve Y = SCREEN_H/2
WIN_SCORE, 7, points needed to win (1..15)
SERVE_FRAMES, 60, frames the ball is held at centre before play
SERVE_VX, 2, serve X speed magnitude (8-bit, 1..127)
SERVE_VY, 1, serve Y speed (8-bit two's complement)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame
start  in  1  start/restart request, level, sampled each cycle
phys_done  in  1  one-cycle pulse: physics finished the requested step
phys_miss  in  2  valid with phys_done; bit0 = right paddle missed, bit1 = left paddle missed
phys_step  out  1  one-cycle pulse: advance physics one frame
phys_load  out  1  one-cycle pulse: physics loads ball_pos_init/ball_vel_init
ball_pos_init  out  32  {X[31:16], Y[15:0]}
ball_vel_init  out  16  {VX[15:8], VY[7:0]}, two's complement
score_left  out  4  left player points
score_right  out  4  right player points
winner  out  2  01 = left won, 10 = right won, 00 = none
game_state  out  3  current FSM state encoding
frame_overrun  out  1  sticky: frame_tick arrived while waiting on physics

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; serve counter 0; serve direction = toward right (VX positive).
- Outputs registered; pulses last exactly one clk.
- States: IDLE=0, SERVE=1, PLAY=2, WAIT=3, SCORE=4, OVER=5.
- IDLE: on start=1, clear scores and winner, then go to SERVE.
- SERVE, entry cycle:
  - pulse phys_load; ball_pos_init = {SCREEN_W/2, SCREEN_H/2}.
  - ball_vel_init = {+SERVE_VX or -SERVE_VX per serve direction, SERVE_VY}.
  - load counter with SERVE_FRAMES.
  - Decrement on each frame_tick; on the tick where counter = 1, go to PLAY. SERVE_FRAMES = 0 is treated as 1.
  - ball_pos_init/ball_vel_init hold their values until the next serve.
- PLAY: on frame_tick, pulse phys_step the next cycle and enter WAIT.
- WAIT: hold until phys_done.
  - phys_miss = 00: return to PLAY.
  - Otherwise go to SCORE.
  - A frame_tick seen in WAIT (including the same cycle as phys_done) sets frame_overrun. The tick is dropped, not queued.
- SCORE, one cycle:
  - miss bit0: score_left += 1; next serve toward left (VX negative).
  - miss bit1: score_right += 1; next serve toward right.
  - miss 11 (simultaneous): no score change; serve direction toggles.
  - If an updated score == WIN_SCORE: set winner, go to OVER. Otherwise go to SERVE.
  - Scores saturate at 15, never wrap.
- OVER: scores and winner held. start=1 clears scores, winner and frame_overrun, then goes to SERVE. start is level-sensitive, so holding it restarts immediately.
- frame_overrun clears only on reset or on restart from OVER.
- phys_done outside WAIT is ignored. frame_tick outside SERVE/PLAY/WAIT is ignored.
- rst asserted mid-game (any state) returns immediately to IDLE with all outputs 0. No phys_step/phys_load pulse is emitted on release.

Test Plan:
- Reset, then start=1 for 1 cycle → SERVE; phys_load pulse with ball_pos_init=0x014000F0, ball_vel_init=0x0201; after 60 frame_ticks → state PLAY.
- PLAY, frame_tick → phys_step pulse one cycle later; phys_done with miss=00 → back to PLAY; scores 0/0.
- phys_done with miss=01 → score_left=1, next SERVE ball_vel_init=0xFE01; miss=10 → score_right=1, next serve VX=0x02.
- miss=11 → scores unchanged, serve direction flips relative to previous.
- Drive left to 7 points → winner=01, state OVER; further frame_ticks/phys_done produce no pulses; start → scores 0, SERVE.
- frame_tick during WAIT → frame_overrun=1 and stays set through later frames; rst low mid-WAIT → all outputs 0, state IDLE asynchronously.
